dadda_tree: RTL and testbench

DADDA_TREE -- requirements
Module: dadda_tree

---
 rtl/dadda_tree.sv | 177 +++++++++++++++++
 tb/tb_dadda_tree.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dadda_tree.sv
// Dadda reduction tree for a 16x16 radix-4 Booth multiplier.
// The eight partial products and the negation-correction row are compressed
// column by column with full and half adders through the heights
// 9 -> 6 -> 4 -> 3 -> 2. The two surviving rows are registered as out0/out1.
// There is no final carry-propagate adder.
module dadda_tree (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] pp0,
    input  logic [18:0] pp1,
    input  logic [18:0] pp2,
    input  logic [18:0] pp3,
    input  logic [18:0] pp4,
    input  logic [18:0] pp5,
    input  logic [18:0] pp6,
    input  logic [17:0] pp7,
    input  logic [7:0]  sign,
    output logic [31:0] out0,
    output logic [31:0] out1
);

    localparam int NCOL   = 32;
    localparam int MAXH   = 9;
    localparam int NSTAGE = 4;
    // Dadda target heights, one per reduction stage
    localparam int DTGT [NSTAGE] = '{6, 4, 3, 2};

    logic [31:0] out0_d;
    logic [31:0] out1_d;
    logic [31:0] out0_q;
    logic [31:0] out1_q;

    // Build the bit matrix, then run each Dadda stage, processing columns
    // LSB first so that the carries arriving from column c-1 in the current
    // stage are counted against column c's target height. All loop bounds and
    // column heights are structural constants, so this unrolls into a fixed
    // network of full and half adders.
    always_comb begin : reduce
        logic [MAXH-1:0] cur_b [NCOL];
        logic [MAXH-1:0] nxt_b [NCOL];
        int              cur_h [NCOL];
        int              nxt_h [NCOL];
        logic [18:0]     mid_pp [6];
        int              idx;
        int              eff;
        int              col;
        int              nc;
        logic            fa_a;
        logic            fa_b;
        logic            fa_c;

        for (int c = 0; c < NCOL; c++) begin
            cur_b[c] = '0;
            cur_h[c] = 0;
            nxt_b[c] = '0;
            nxt_h[c] = 0;
        end
        idx  = 0;
        eff  = 0;
        col  = 0;
        nc   = 0;
        fa_a = 1'b0;
        fa_b = 1'b0;
        fa_c = 1'b0;

        mid_pp[0] = pp1;
        mid_pp[1] = pp2;
        mid_pp[2] = pp3;
        mid_pp[3] = pp4;
        mid_pp[4] = pp5;
        mid_pp[5] = pp6;

        // pp0 occupies columns 0..19
        for (int b = 0; b < 20; b++) begin
            cur_b[b][cur_h[b]] = pp0[b];
            cur_h[b] = cur_h[b] + 1;
        end
        // pp1..pp6 occupy columns 2i..2i+18
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < 19; b++) begin
                col = 2 * (i + 1) + b;
                cur_b[col][cur_h[col]] = mid_pp[i][b];
                cur_h[col] = cur_h[col] + 1;
            end
        end
        // pp7 occupies columns 14..31
        for (int b = 0; b < 18; b++) begin
            col = 14 + b;
            cur_b[col][cur_h[col]] = pp7[b];
            cur_h[col] = cur_h[col] + 1;
        end
        // negation-correction bits sit at even columns 0..14
        for (int i = 0; i < 8; i++) begin
            col = 2 * i;
            cur_b[col][cur_h[col]] = sign[i];
            cur_h[col] = cur_h[col] + 1;
        end

        for (int s = 0; s < NSTAGE; s++) begin
            for (int c = 0; c < NCOL; c++) begin
                nxt_b[c] = '0;
                nxt_h[c] = 0;
            end
            for (int c = 0; c < NCOL; c++) begin
                idx = 0;
                // nxt_h[c] holds only carries from column c-1 at this point
                eff = cur_h[c] + nxt_h[c];
                for (int k = 0; k < MAXH; k++) begin
                    if (eff > DTGT[s]) begin
                        if ((eff - DTGT[s] >= 2) && (cur_h[c] - idx >= 3)) begin
                            fa_a = cur_b[c][idx];
                            fa_b = cur_b[c][idx + 1];
                            fa_c = cur_b[c][idx + 2];
                            nxt_b[c][nxt_h[c]] = fa_a ^ fa_b ^ fa_c;
                            nxt_h[c] = nxt_h[c] + 1;
                            // carry out of column 31 falls off (mod 2^32)
                            if (c < NCOL - 1) begin
                                nc = c + 1;
                                nxt_b[nc][nxt_h[nc]] = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
                                nxt_h[nc] = nxt_h[nc] + 1;
                            end
                            idx = idx + 3;
                            eff = eff - 2;
                        end else if (cur_h[c] - idx >= 2) begin
                            fa_a = cur_b[c][idx];
                            fa_b = cur_b[c][idx + 1];
                            nxt_b[c][nxt_h[c]] = fa_a ^ fa_b;
                            nxt_h[c] = nxt_h[c] + 1;
                            if (c < NCOL - 1) begin
                                nc = c + 1;
                                nxt_b[nc][nxt_h[nc]] = fa_a & fa_b;
                                nxt_h[nc] = nxt_h[nc] + 1;
                            end
                            idx = idx + 2;
                            eff = eff - 1;
                        end
                    end
                end
                // bits not consumed by an adder pass straight through
                for (int k = 0; k < MAXH; k++) begin
                    if (idx < cur_h[c]) begin
                        nxt_b[c][nxt_h[c]] = cur_b[c][idx];
                        nxt_h[c] = nxt_h[c] + 1;
                        idx = idx + 1;
                    end
                end
            end
            for (int c = 0; c < NCOL; c++) begin
                cur_b[c] = nxt_b[c];
                cur_h[c] = nxt_h[c];
            end
        end

        // at most two bits remain per column; empty slots are already zero
        out0_d = '0;
        out1_d = '0;
        for (int c = 0; c < NCOL; c++) begin
            out0_d[c] = cur_b[c][0];
            out1_d[c] = cur_b[c][1];
        end
    end

    // Output register: clears on reset, otherwise loads the reduced rows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

    assign out0 = out0_q;
    assign out1 = out1_q;

endmodule

// File: tb/tb_dadda_tree.sv
// Bench for dadda_tree: directed table of vectors with hand-computed sums,
// hand sequences around reset, and a random soak against an arithmetic model.
module tb_dadda_tree;

    logic        clk;
    logic        rst_n;
    logic [19:0] pp0;
    logic [18:0] pp1, pp2, pp3, pp4, pp5, pp6;
    logic [17:0] pp7;
    logic [7:0]  sign;
    logic [31:0] out0, out1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [19:0] p0;
        logic [18:0] p1;
        logic [18:0] p2;
        logic [18:0] p3;
        logic [18:0] p4;
        logic [18:0] p5;
        logic [18:0] p6;
        logic [17:0] p7;
        logic [7:0]  sg;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    dadda_tree dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pp0  (pp0),
        .pp1  (pp1),
        .pp2  (pp2),
        .pp3  (pp3),
        .pp4  (pp4),
        .pp5  (pp5),
        .pp6  (pp6),
        .pp7  (pp7),
        .sign (sign),
        .out0 (out0),
        .out1 (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain weighted sum of all rows, mod 2^32
    function automatic logic [31:0] ref_sum(input vec_t v);
        logic [31:0] acc;
        acc = 32'(v.p0)
            + (32'(v.p1) << 2)
            + (32'(v.p2) << 4)
            + (32'(v.p3) << 6)
            + (32'(v.p4) << 8)
            + (32'(v.p5) << 10)
            + (32'(v.p6) << 12)
            + (32'(v.p7) << 14);
        for (int i = 0; i < 8; i++) begin
            acc = acc + (32'(v.sg[i]) << (2 * i));
        end
        return acc;
    endfunction

    task automatic drive(input vec_t v);
        pp0  = v.p0;
        pp1  = v.p1;
        pp2  = v.p2;
        pp3  = v.p3;
        pp4  = v.p4;
        pp5  = v.p5;
        pp6  = v.p6;
        pp7  = v.p7;
        sign = v.sg;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    function automatic logic [31:0] row_sum();
        return out0 + out1;
    endfunction

    initial begin
        vec_t v;
        vec_t ones;

        //               p0        p1        p2        p3        p4        p5        p6        p7        sg     exp
        tbl[0]  = '{20'h00001, 19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h0,     8'h00, 32'h00000001};
        tbl[1]  = '{20'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h3FFFF, 8'h00, 32'hFFFFC000};
        tbl[2]  = '{20'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h0,     8'hFF, 32'h00005555};
        tbl[3]  = '{20'hFFFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 18'h3FFFF, 8'hFF, 32'hAAB00000};
        tbl[4]  = '{20'h0,     19'h0,     19'h0,     19'h00001, 19'h0,     19'h0,     19'h0,     18'h0,     8'h00, 32'h00000040};
        tbl[5]  = '{20'hFFFFF, 19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h0,     8'h00, 32'h000FFFFF};
        tbl[6]  = '{20'h0,     19'h7FFFF, 19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h0,     8'h00, 32'h001FFFFC};
        tbl[7]  = '{20'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h40000, 18'h0,     8'h00, 32'h40000000};
        tbl[8]  = '{20'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h30000, 8'h80, 32'hC0004000};
        tbl[9]  = '{20'hFFFFF, 19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h0,     8'h01, 32'h00100000};
        tbl[10] = '{20'h0,     19'h0,     19'h7FFFF, 19'h0,     19'h00001, 19'h0,     19'h0,     18'h0,     8'h00, 32'h008000F0};
        tbl[11] = '{20'h0,     19'h2AAAA, 19'h0,     19'h0,     19'h0,     19'h55555, 19'h0,     18'h0,     8'h00, 32'h155FFEA8};
        tbl[12] = '{20'h04000, 19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     19'h0,     18'h3FFFF, 8'h00, 32'h00000000};

        ones = tbl[3];

        // reset held for two edges with all-ones inputs
        rst_n = 1'b0;
        drive(ones);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_out0", out0, 32'h0);
        check("reset_out1", out1, 32'h0);

        // first edge out of reset loads the inputs present at that edge
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", row_sum(), 32'hAAB00000);

        // directed table, back to back
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d", i), row_sum(), tbl[i].exp);
        end

        // mid-stream reset: in-flight all-ones result is discarded
        drive(ones);
        @(posedge clk);
        #1;
        check("pre_reset", row_sum(), 32'hAAB00000);
        drive(tbl[1]);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_out0", out0, 32'h0);
        check("mid_reset_out1", out1, 32'h0);
        rst_n = 1'b1;
        drive(tbl[0]);
        @(posedge clk);
        #1;
        check("post_reset", row_sum(), 32'h00000001);

        // random soak with one reset pulse in the middle
        for (int i = 0; i < 10000; i++) begin
            v.p0 = 20'($urandom());
            v.p1 = 19'($urandom());
            v.p2 = 19'($urandom());
            v.p3 = 19'($urandom());
            v.p4 = 19'($urandom());
            v.p5 = 19'($urandom());
            v.p6 = 19'($urandom());
            v.p7 = 18'($urandom());
            v.sg = 8'($urandom());
            drive(v);
            rst_n = (i == 5000) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (i == 5000) begin
                check("soak_reset_out0", out0, 32'h0);
                check("soak_reset_out1", out1, 32'h0);
            end else begin
                check($sformatf("soak%0d", i), row_sum(), ref_sum(v));
            end
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
